// File: rtl/fft_frame_collector_if.sv
// rtl/fft_frame_collector_if.sv - sample input stream and frame output bundle for fft_frame_collector
interface fft_frame_collector_if #(
    parameter int N   = 16,
    parameter int MSB = 8
);
    logic                 in_valid;
    logic                 in_sof;
    logic [MSB-1:0]       in_re;
    logic [MSB-1:0]       in_im;
    logic                 in_ready;
    logic [N*2*MSB-1:0]   data_bus;
    logic                 start_spi;
    logic                 tx_busy;
    logic                 sync_err;

    // Upstream FFT source / downstream SPI stage view
    modport master (
        output in_valid, in_sof, in_re, in_im,
        input  in_ready, data_bus, start_spi, tx_busy, sync_err
    );

    // Collector view
    modport slave (
        input  in_valid, in_sof, in_re, in_im,
        output in_ready, data_bus, start_spi, tx_busy, sync_err
    );
endinterface

// File: rtl/fft_frame_collector.sv
// rtl/fft_frame_collector.sv - assembles N FFT bins into a held, flattened frame for the SPI stage
module fft_frame_collector #(
    parameter int N           = 16,
    parameter int MSB         = 8,
    parameter int HOLD_CYCLES = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_frame_collector_if.slave bus
);
    localparam int IDX_W  = $clog2(N);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int BIN_W  = 2 * MSB;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  AFTER_SOF = IDX_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N*BIN_W-1:0]  capture_q;
    logic [N*BIN_W-1:0]  data_bus_q;
    logic                start_spi_q;
    logic                sync_err_q;

    logic                accept;
    logic                cap_we;
    logic [IDX_W-1:0]    cap_idx;
    logic                transfer;
    logic                sync_err_d;

    assign bus.in_ready  = (state_q == FILL);
    assign bus.data_bus  = data_bus_q;
    assign bus.start_spi = start_spi_q;
    assign bus.tx_busy   = (hold_cnt_q != '0);
    assign bus.sync_err  = sync_err_q;

    // State register: FILL collects bins, FULL waits for the hold-off to expire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, write index, capture strobe, transfer decision and hold-off count
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        cap_we     = 1'b0;
        cap_idx    = wr_idx_q;
        transfer   = 1'b0;
        sync_err_d = 1'b0;
        accept     = bus.in_valid && (state_q == FILL);
        hold_cnt_d = (hold_cnt_q != '0) ? hold_cnt_q - 1'b1 : hold_cnt_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    cap_we = 1'b1;
                    if (bus.in_sof) begin
                        // Start-of-frame always restarts at bin 0; a partial frame is dropped
                        cap_idx    = '0;
                        wr_idx_d   = AFTER_SOF;
                        sync_err_d = (wr_idx_q != '0);
                    end else if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = FULL;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            FULL: begin
                // Transfer only once the previous frame's hold-off is over; reload starts the next one
                if (hold_cnt_q == '0) begin
                    transfer   = 1'b1;
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = FILL;
                end
            end
        endcase
    end

    // Write index and hold-off counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Capture buffer: bin k holds {im, re} so re lands on word 2k and im on word 2k+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capture_q <= '0;
        end else if (cap_we) begin
            capture_q[cap_idx*BIN_W +: BIN_W] <= {bus.in_im, bus.in_re};
        end
    end

    // Output register: the whole frame moves at once and stays put through the hold-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_bus_q <= '0;
        end else if (transfer) begin
            data_bus_q <= capture_q;
        end
    end

    // Registered single-cycle pulses for frame start and mid-frame resync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_spi_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            start_spi_q <= transfer;
            sync_err_q  <= sync_err_d;
        end
    end
endmodule

// File: tb/tb_fft_frame_collector.sv
// tb/tb_fft_frame_collector.sv - randomized self-checking bench for fft_frame_collector
module tb_fft_frame_collector;
    localparam int N    = 16;
    localparam int MSB  = 8;
    localparam int HOLD = 40;
    localparam int W    = N * 2 * MSB;
    localparam int BOUND = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_acc = 0;

    fft_frame_collector_if #(.N(N), .MSB(MSB)) bus ();

    fft_frame_collector #(.N(N), .MSB(MSB), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Observed frames and activity, sampled on the falling edge
    logic [W-1:0] got_frames[$];
    int           start_cycles[$];
    logic         ready_at_start[$];
    logic [W-1:0] prev_bus = '0;
    int bus_glitch = 0, sync_seen = 0, busy_run = 0, last_busy_run = 0, ready_low = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_bus = bus.data_bus;
            busy_run = 0;
        end else begin
            if (bus.start_spi) begin
                got_frames.push_back(bus.data_bus);
                start_cycles.push_back(cyc);
                ready_at_start.push_back(bus.in_ready);
            end else if (bus.data_bus !== prev_bus) begin
                bus_glitch++;
            end
            if (bus.sync_err) sync_seen++;
            if (bus.tx_busy) busy_run++;
            else begin
                if (busy_run != 0) last_busy_run = busy_run;
                busy_run = 0;
            end
            if (!bus.in_ready) ready_low++;
            prev_bus = bus.data_bus;
        end
    end

    // Reference model: bins since the last frame start, packed once N have arrived
    logic [2*MSB-1:0] cur[$];
    logic [W-1:0]     exp_frames[$];
    int               exp_sync = 0;

    function automatic void model_accept(input logic [MSB-1:0] re, input logic [MSB-1:0] im, input logic sof);
        logic [W-1:0] f;
        if (sof) begin
            if (cur.size() != 0) exp_sync++;
            cur.delete();
        end
        cur.push_back({im, re});
        if (cur.size() == N) begin
            f = '0;
            for (int k = 0; k < N; k++) begin
                f[(2*k)*MSB +: MSB]   = cur[k][MSB-1:0];
                f[(2*k+1)*MSB +: MSB] = cur[k][2*MSB-1:MSB];
            end
            exp_frames.push_back(f);
            cur.delete();
        end
    endfunction

    function automatic logic [W-1:0] pack_bins(input logic [MSB-1:0] r[N], input logic [MSB-1:0] i[N]);
        logic [W-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) begin
            f[(2*k)*MSB +: MSB]   = r[k];
            f[(2*k+1)*MSB +: MSB] = i[k];
        end
        return f;
    endfunction

    task automatic send(input logic [MSB-1:0] re, input logic [MSB-1:0] im, input logic sof);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_re    = re;
        bus.in_im    = im;
        while (!bus.in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) begin
            total++; bad++;
            $display("FAIL accept_timeout got=stalled want=accepted");
        end else begin
            model_accept(re, im, sof);
        end
        @(posedge clk);
        #1;
        last_acc     = cyc;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [MSB-1:0] r[N], input logic [MSB-1:0] i[N]);
        for (int k = 0; k < N; k++) send(r[k], i[k], k == 0);
    endtask

    task automatic rand_bins(output logic [MSB-1:0] r[N], output logic [MSB-1:0] i[N]);
        for (int k = 0; k < N; k++) begin
            r[k] = MSB'($urandom);
            i[k] = MSB'($urandom);
        end
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (got_frames.size() < target && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (got_frames.size() < target) begin
            total++; bad++;
            $display("FAIL frame_timeout got=%0d want=%0d", got_frames.size(), target);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.tx_busy || !bus.in_ready) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_re = '0; bus.in_im = '0;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.data_bus !== '0) begin bad++; $display("FAIL reset_data_bus got=%h want=0", bus.data_bus); end
        total++; if (bus.start_spi !== 1'b0) begin bad++; $display("FAIL reset_start_spi got=%b want=0", bus.start_spi); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy got=%b want=0", bus.tx_busy); end
        total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL reset_sync_err got=%b want=0", bus.sync_err); end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [MSB-1:0] r[N], i[N];
        int base;
        wait_idle();
        base = got_frames.size();
        for (int k = 0; k < N; k++) begin
            r[k] = MSB'(k);
            i[k] = MSB'(8'h80 + k);
        end
        send_frame(r, i);
        wait_frames(base + 1);
        if (got_frames.size() > base) begin
            total++; if (start_cycles[base] !== last_acc + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", start_cycles[base], last_acc + 1); end
            total++; if (got_frames[base] !== pack_bins(r, i)) begin bad++; $display("FAIL single_data got=%h want=%h", got_frames[base], pack_bins(r, i)); end
            total++; if (ready_at_start[base] !== 1'b1) begin bad++; $display("FAIL single_ready_at_start got=%b want=1", ready_at_start[base]); end
        end
        repeat (HOLD + 3) @(negedge clk);
        total++; if (last_busy_run !== HOLD) begin bad++; $display("FAIL single_busy_len got=%0d want=%0d", last_busy_run, HOLD); end
    endtask

    task automatic test_back_pressure();
        logic [MSB-1:0] ra[N], ia[N], rb[N], ib[N];
        int base, e0, g0, low0, t2;
        wait_idle();
        base = got_frames.size();
        e0   = exp_frames.size();
        g0   = bus_glitch;
        rand_bins(ra, ia);
        rand_bins(rb, ib);
        send_frame(ra, ia);
        send_frame(rb, ib);
        t2   = last_acc;
        low0 = ready_low;
        wait_frames(base + 2);
        if (got_frames.size() >= base + 2) begin
            total++; if (t2 !== start_cycles[base] + 16) begin bad++; $display("FAIL bp_second_complete got=%0d want=%0d", t2, start_cycles[base] + 16); end
            total++; if (start_cycles[base+1] - start_cycles[base] !== HOLD + 1) begin bad++; $display("FAIL bp_spacing got=%0d want=%0d", start_cycles[base+1] - start_cycles[base], HOLD + 1); end
            total++; if (ready_low - low0 !== HOLD - 15) begin bad++; $display("FAIL bp_ready_low got=%0d want=%0d", ready_low - low0, HOLD - 15); end
            total++; if (got_frames[base] !== exp_frames[e0]) begin bad++; $display("FAIL bp_frame_a got=%h want=%h", got_frames[base], exp_frames[e0]); end
            total++; if (got_frames[base+1] !== pack_bins(rb, ib)) begin bad++; $display("FAIL bp_frame_b got=%h want=%h", got_frames[base+1], pack_bins(rb, ib)); end
        end
        total++; if (bus_glitch !== g0) begin bad++; $display("FAIL bp_bus_stable got=%0d want=%0d", bus_glitch - g0, 0); end
    endtask

    task automatic test_resync();
        int base, e0, s0, es0;
        wait_idle();
        base = got_frames.size();
        e0   = exp_frames.size();
        s0   = sync_seen;
        es0  = exp_sync;
        for (int k = 0; k < 6; k++) send(MSB'($urandom), MSB'($urandom), k == 0);
        send(8'hAA, MSB'($urandom), 1'b1);
        for (int k = 0; k < N - 1; k++) send(MSB'($urandom), MSB'($urandom), 1'b0);
        wait_frames(base + 1);
        repeat (4) @(negedge clk);
        total++; if (sync_seen - s0 !== 1) begin bad++; $display("FAIL resync_pulses got=%0d want=1", sync_seen - s0); end
        total++; if (sync_seen - s0 !== exp_sync - es0) begin bad++; $display("FAIL resync_model_pulses got=%0d want=%0d", sync_seen - s0, exp_sync - es0); end
        total++; if (got_frames.size() !== base + 1) begin bad++; $display("FAIL resync_frame_count got=%0d want=%0d", got_frames.size() - base, 1); end
        if (got_frames.size() > base) begin
            total++; if (got_frames[base][MSB-1:0] !== 8'hAA) begin bad++; $display("FAIL resync_word0 got=%h want=aa", got_frames[base][MSB-1:0]); end
            total++; if (got_frames[base] !== exp_frames[e0]) begin bad++; $display("FAIL resync_frame got=%h want=%h", got_frames[base], exp_frames[e0]); end
            total++; if (start_cycles[base] !== last_acc + 1) begin bad++; $display("FAIL resync_latency got=%0d want=%0d", start_cycles[base], last_acc + 1); end
        end
    endtask

    task automatic test_valid_gaps();
        logic [MSB-1:0] r[N], i[N];
        int base;
        wait_idle();
        base = got_frames.size();
        rand_bins(r, i);
        send_frame(r, i);
        wait_frames(base + 1);
        wait_idle();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                bus.in_re = MSB'($urandom);
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
            send(r[k], i[k], k == 0);
        end
        wait_frames(base + 2);
        if (got_frames.size() >= base + 2) begin
            total++; if (got_frames[base] !== pack_bins(r, i)) begin bad++; $display("FAIL gaps_reference got=%h want=%h", got_frames[base], pack_bins(r, i)); end
            total++; if (got_frames[base+1] !== got_frames[base]) begin bad++; $display("FAIL gaps_match got=%h want=%h", got_frames[base+1], got_frames[base]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [MSB-1:0] r[N], i[N];
        int base, n;
        for (int k = 0; k < 7; k++) send(MSB'($urandom), MSB'($urandom), k == 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        cur.delete();
        total++; if (bus.data_bus !== '0) begin bad++; $display("FAIL rstmid_data_bus got=%h want=0", bus.data_bus); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_tx_busy got=%b want=0", bus.tx_busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", bus.in_ready); end
        @(negedge clk);
        #2 rst = 1'b0;
        base = got_frames.size();
        rand_bins(r, i);
        send_frame(r, i);
        n = 0;
        while (!bus.start_spi && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        cur.delete();
        total++; if (bus.start_spi !== 1'b0) begin bad++; $display("FAIL rstpulse_start_spi got=%b want=0", bus.start_spi); end
        total++; if (bus.data_bus !== '0) begin bad++; $display("FAIL rstpulse_data_bus got=%h want=0", bus.data_bus); end
        total++; if (got_frames.size() !== base + 1) begin bad++; $display("FAIL rstmid_frame_count got=%0d want=%0d", got_frames.size() - base, 1); end
        else begin
            total++; if (got_frames[base] !== pack_bins(r, i)) begin bad++; $display("FAIL rstmid_frame got=%h want=%h", got_frames[base], pack_bins(r, i)); end
        end
        @(negedge clk);
        #2 rst = 1'b0;
        base = got_frames.size();
        rand_bins(r, i);
        send_frame(r, i);
        wait_frames(base + 1);
        if (got_frames.size() > base) begin
            total++; if (got_frames[base] !== pack_bins(r, i)) begin bad++; $display("FAIL rstafter_frame got=%h want=%h", got_frames[base], pack_bins(r, i)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_pressure();
        test_resync();
        test_valid_gaps();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end
endmodule
